data_bus_sram_responder: RTL and testbench
==========================================

Name: data_bus_sram_responder

Overview:
Word-addressed SRAM model that acts as the responder (device) end of the core data bus req/gnt/rvalid protocol. It accepts requests from the load-store unit, applies byte-enabled writes, returns read data in order, and flags out-of-range accesses with an error response. Grant delay and response latency are configurable so that the LSU wait states (grant stall, misaligned split, back-to-back) can be exercised in SoC-level and block-level benches.

Parameters:
MemWords, 1024, number of 32-bit words in the array (power of two, >=4)
AddrBase, 32'h0001_0000, byte base address of the array (word aligned)
GntDelay, 0, consecutive cycles req must be high before gnt is given (0 = same cycle)
RspLatency, 1, minimum cycles from gnt to rvalid (>=1)
RspDepth, 2, maximum outstanding granted-but-unanswered requests (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
data_req_i  in  1  request valid, held by initiator until gnt
data_gnt_o  out  1  request accepted this cycle
data_rvalid_o  out  1  response valid, one cycle per granted request
data_err_o  out  1  response error, qualified by rvalid
data_addr_i  in  32  byte address; bits [1:0] ignored
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data, already lane-aligned by initiator
data_rdata_o  out  32  read data, qualified by rvalid
busy_o  out  1  outstanding count != 0
outstanding_o  out  $clog2(RspDepth+1)  number of outstanding requests

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clk_i is the clock. During reset, gnt, rvalid, err, busy = 0; rdata = 0; outstanding = 0; grant counter = 0; FIFO empty. Memory contents are not reset.
- Reset asserted mid-operation drops all pending responses; no rvalid is issued for them afterwards.
- Grant counter:
  - Increments each cycle that req=1 and gnt=0; saturates at GntDelay.
  - Clears on gnt, and on any cycle with req=0.
- Grant condition: gnt = req & (cnt == GntDelay) & (outstanding < RspDepth, or a response pops this same cycle). With GntDelay=0 the path from req to gnt is combinational.
- Decode on the gnt cycle:
  - widx = (addr[31:2] - AddrBase[31:2]), 32-bit unsigned.
  - in_range = widx < MemWords.
- Write, in range: each byte lane i with be[i]=1 updates mem[widx][8i+7:8i] at the gnt clock edge. be=0000 is a legal no-op write.
- Read, in range: all 4 lanes are returned regardless of be.
- Out of range: the write has no effect; the response has err=1 and rdata=0.
- Response entry: {err, rdata} is pushed on the gnt edge with its countdown set to RspLatency-1. Write responses carry rdata=0.
- Countdowns: all pending entry countdowns decrement each cycle until 0.
- Response issue:
  - The head entry issues rvalid=1 for exactly one cycle once its countdown is 0, then pops.
  - Responses are strictly in grant order; never more than one rvalid per cycle.
- Latency: with RspLatency=1 and GntDelay=0, a request in cycle N is granted in N and answered in N+1.
- Throughput: one request per cycle when RspDepth >= RspLatency+1.
- Ordering: a read granted the cycle after a write to the same word returns the newly written data. A grant and a pop in the same cycle are both allowed when the FIFO is full.
- The responder never issues rvalid without a prior gnt. rdata_o holds 0 when rvalid=0.
- Misaligned LSU accesses arrive as two independent requests, and each is answered independently. An error on the first request does not suppress the second.
- outstanding_o = pushes - pops, counted at the clock edge; busy_o = (outstanding_o != 0).

Decomposition:
- Shared package data_bus_pkg holds:
  - rsp_entry_t {err, rdata[31:0]};
  - the localparam word widths;
  - the function in_range(addr, base, words).
- One sub-module, data_bus_rsp_fifo: parameterised depth and entry type, per-entry latency countdown, push/pop/full/count outputs, with head_ready meaning countdown == 0.
- The top level holds the memory array, the grant counter and the decode.

Test Plan:
- Reset value checks:
  - Stimulus: assert rst_ni=0, then release.
  - Required: gnt/rvalid/err/busy = 0, rdata = 0, outstanding = 0.
- Aligned write then read, defaults:
  - Stimulus: write addr 0x0001_0010, be 1111, wdata 0xDEADBEEF, then read the same address.
  - Required: gnt same cycle as req; rvalid one cycle later; read rdata 0xDEADBEEF, err 0.
- Byte-lane write:
  - Stimulus: preload 0x11223344; write be 0100 with wdata 0x00AA0000; then read.
  - Required: read returns 0x11AA3344.
- Out of range:
  - Stimulus: read 0x0000_0000, then write 0x0001_1000 (widx = 1024).
  - Required: both responses err=1, rdata=0; memory unchanged.
- Stall and back-pressure:
  - Stimulus: GntDelay=2, RspLatency=3, RspDepth=2; hold req for 4 back-to-back reads.
  - Required: first gnt 2 cycles after req rises; outstanding never exceeds 2; rvalids arrive in order with correct data.
- Misaligned word sequence and mid-operation reset:
  - Stimulus: two consecutive granted requests to 0x0001_0000 and 0x0001_0004; assert rst_ni between the grant and the rvalid.
  - Required: no rvalid after reset; outstanding = 0; a new request after reset is served normally.

Source files
------------

// File: rtl/data_bus_pkg.sv
// Shared types and helpers for the core data bus responder.
// Holds the response entry layout, the word geometry and the address decode.
package data_bus_pkg;

    localparam int unsigned WordW    = 32;
    localparam int unsigned ByteW    = 8;
    localparam int unsigned NumBytes = WordW / ByteW;

    typedef struct packed {
        logic             err;
        logic [WordW-1:0] rdata;
    } rsp_entry_t;

    // Word offset of a byte address from the array base; wraps for addresses below base.
    function automatic logic [31:0] word_index(logic [31:0] addr, logic [31:0] base);
        return {2'b00, addr[31:2]} - {2'b00, base[31:2]};
    endfunction

    function automatic logic in_range(logic [31:0] addr, logic [31:0] base, int unsigned words);
        return word_index(addr, base) < words;
    endfunction

endpackage

// File: rtl/data_bus_rsp_fifo.sv
// In-order response queue with a per-entry latency countdown.
// The head may leave only once its countdown has reached zero.
module data_bus_rsp_fifo
    import data_bus_pkg::*;
#(
    parameter int unsigned Depth   = 2,
    parameter int unsigned Latency = 1,
    parameter type         entry_t = rsp_entry_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    output logic                         head_ready_o,
    output entry_t                       head_data_o,
    output logic                         full_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned CdW  = (Latency > 1) ? $clog2(Latency) : 1;

    entry_t          data_q [Depth];
    logic [CdW-1:0]  cd_q   [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    // NOTE: storage holds no reset; an entry is only read after a push has written it.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            for (int i = 0; i < int'(Depth); i++) begin
                if (push_i && (wr_ptr_q == PtrW'(i))) begin
                    cd_q[i] <= CdW'(Latency - 1);
                end else if (cd_q[i] != '0) begin
                    cd_q[i] <= cd_q[i] - 1'b1;
                end
            end
        end
    end

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        head_ready_o = 1'b0;
        if (count_q != '0) begin
            head_ready_o = (cd_q[rd_ptr_q] == '0);
        end
    end

    assign head_data_o = data_q[rd_ptr_q];
    assign full_o      = (count_q == CntW'(Depth));
    assign count_o     = count_q;

endmodule

// File: rtl/data_bus_sram_responder.sv
// Word-addressed SRAM acting as the device end of the data bus req/gnt/rvalid protocol.
// Grant delay and response latency are tunable to exercise LSU wait states.
module data_bus_sram_responder
    import data_bus_pkg::*;
#(
    parameter int unsigned MemWords   = 1024,
    parameter logic [31:0] AddrBase   = 32'h0001_0000,
    parameter int unsigned GntDelay   = 0,
    parameter int unsigned RspLatency = 1,
    parameter int unsigned RspDepth   = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            data_req_i,
    output logic                            data_gnt_o,
    output logic                            data_rvalid_o,
    output logic                            data_err_o,
    input  logic [31:0]                     data_addr_i,
    input  logic                            data_we_i,
    input  logic [3:0]                      data_be_i,
    input  logic [31:0]                     data_wdata_i,
    output logic [31:0]                     data_rdata_o,
    output logic                            busy_o,
    output logic [$clog2(RspDepth+1)-1:0]   outstanding_o
);

    localparam int unsigned AddrW = $clog2(MemWords);
    localparam int unsigned CntW  = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
    localparam int unsigned OutW  = $clog2(RspDepth + 1);

    logic [WordW-1:0] mem_q [MemWords];
    logic [CntW-1:0]  cnt_q;
    logic             cnt_at_limit;
    logic             hit;
    logic [AddrW-1:0] mem_idx;
    logic             fifo_full, head_ready, pop;
    rsp_entry_t       rsp_push, rsp_head;
    logic [OutW-1:0]  count;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^data_addr_i[1:0];

    assign cnt_at_limit = (cnt_q == CntW'(GntDelay));
    assign pop          = head_ready;
    // A full queue may still accept when its head leaves in the same cycle.
    assign data_gnt_o   = rst_ni & data_req_i & cnt_at_limit & (~fifo_full | pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!data_req_i || data_gnt_o) begin
            cnt_q <= '0;
        end else if (!cnt_at_limit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit     = in_range(data_addr_i, AddrBase, MemWords);
    assign mem_idx = AddrW'(word_index(data_addr_i, AddrBase));

    always_ff @(posedge clk_i) begin
        if (data_gnt_o && data_we_i && hit) begin
            for (int i = 0; i < int'(NumBytes); i++) begin
                if (data_be_i[i]) begin
                    mem_q[mem_idx][ByteW*i +: ByteW] <= data_wdata_i[ByteW*i +: ByteW];
                end
            end
        end
    end

    // Writes and out-of-range accesses answer with zero data.
    always_comb begin
        rsp_push       = '0;
        rsp_push.err   = ~hit;
        rsp_push.rdata = (hit && !data_we_i) ? mem_q[mem_idx] : '0;
    end

    data_bus_rsp_fifo #(
        .Depth   (RspDepth),
        .Latency (RspLatency),
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (data_gnt_o),
        .push_data_i  (rsp_push),
        .pop_i        (pop),
        .head_ready_o (head_ready),
        .head_data_o  (rsp_head),
        .full_o       (fifo_full),
        .count_o      (count)
    );

    assign data_rvalid_o = head_ready;
    assign data_err_o    = head_ready & rsp_head.err;
    assign data_rdata_o  = head_ready ? rsp_head.rdata : '0;
    assign outstanding_o = count;
    assign busy_o        = (count != '0);

endmodule

// File: tb/tb_data_bus_sram_responder.sv
// Directed and randomized bench for the data bus SRAM responder, checked against
// a behavioural memory/response model; a second instance runs stalled timing.
module tb_data_bus_sram_responder;

    localparam logic [31:0] Base = 32'h0001_0000;

    logic        clk, rst_n;
    // default-timing instance
    logic        d_req, d_gnt, d_rvalid, d_err, d_we, d_busy;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic [1:0]  d_out;
    // stalled instance: GntDelay=2, RspLatency=3, RspDepth=2
    logic        s_req, s_gnt, s_rvalid, s_err, s_we, s_busy;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic [1:0]  s_out;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [int unsigned];

    data_bus_sram_responder u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i(d_req), .data_gnt_o(d_gnt), .data_rvalid_o(d_rvalid), .data_err_o(d_err),
        .data_addr_i(d_addr), .data_we_i(d_we), .data_be_i(d_be), .data_wdata_i(d_wdata),
        .data_rdata_o(d_rdata), .busy_o(d_busy), .outstanding_o(d_out)
    );

    data_bus_sram_responder #(
        .MemWords(1024), .AddrBase(Base), .GntDelay(2), .RspLatency(3), .RspDepth(2)
    ) u_stall (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i(s_req), .data_gnt_o(s_gnt), .data_rvalid_o(s_rvalid), .data_err_o(s_err),
        .data_addr_i(s_addr), .data_we_i(s_we), .data_be_i(s_be), .data_wdata_i(s_wdata),
        .data_rdata_o(s_rdata), .busy_o(s_busy), .outstanding_o(s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: the array spans Base .. Base+4 KiB; word identity ignores address bits [1:0].
    function automatic bit ref_hit(input logic [31:0] a);
        longint unsigned ua;
        ua = longint'(a & 32'hFFFF_FFFC);
        return (ua >= longint'(Base)) && (ua < longint'(Base) + 4096);
    endfunction

    task automatic model(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output logic e, output logic [31:0] rd);
        int unsigned key;
        logic [31:0] mask, old;
        e  = 1'b1;
        rd = '0;
        if (ref_hit(addr)) begin
            e   = 1'b0;
            key = (addr - Base) / 4;
            if (we) begin
                old  = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                ref_mem[key] = (old & ~mask) | (wd & mask);
            end else begin
                rd = ref_mem[key];
            end
        end
    endtask

    task automatic d_drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wd;
    endtask

    // One isolated transaction on the default instance: grant in the request cycle, answer next cycle.
    task automatic d_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] got);
        logic        e;
        logic [31:0] rd;
        model(we, addr, be, wd, e, rd);
        @(posedge clk); #1;
        d_drive(we, addr, be, wd);
        @(negedge clk);
        check1("d_gnt_same_cycle", d_gnt, 1'b1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check1("d_rvalid_next", d_rvalid, 1'b1);
        check1("d_err", d_err, e);
        check("d_rdata", d_rdata, rd);
        got = d_rdata;
    endtask

    task automatic s_write(input logic [31:0] addr, input logic [31:0] wd);
        int cyc;
        @(posedge clk); #1;
        s_req = 1'b1; s_we = 1'b1; s_addr = addr; s_be = 4'hF; s_wdata = wd;
        cyc = 0;
        @(negedge clk);
        while (!s_gnt && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check1("s_wr_gnt", s_gnt, 1'b1);
        @(posedge clk); #1;
        s_req = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!s_rvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check1("s_wr_rsp", s_rvalid, 1'b1);
        check1("s_wr_err", s_err, 1'b0);
    endtask

    initial begin
        logic [31:0] got, a, wd, s_data [4];
        logic [3:0]  be;
        logic        we, e;
        logic [31:0] rd;
        logic [32:0] exp_q [$];
        logic [32:0] exp_e;
        int          n_gnt, n_rsp, cyc;
        bit          saw_gnt;

        rst_n = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_be = '0; s_wdata = '0;

        // reset state, with a request pending on the zero-delay instance
        d_drive(1'b0, Base, 4'hF, '0);
        repeat (2) @(negedge clk);
        check1("rst_d_gnt", d_gnt, 1'b0);
        check1("rst_d_rvalid", d_rvalid, 1'b0);
        check1("rst_d_err", d_err, 1'b0);
        check1("rst_d_busy", d_busy, 1'b0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_d_out", 32'(d_out), 32'h0);
        check1("rst_s_rvalid", s_rvalid, 1'b0);
        check("rst_s_out", 32'(s_out), 32'h0);
        d_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check1("post_rst_rvalid", d_rvalid, 1'b0);
        check("post_rst_rdata", d_rdata, 32'h0);

        // aligned write then read; the read ignores byte enables
        d_xfer(1'b1, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF, got);
        d_xfer(1'b0, 32'h0001_0010, 4'h0, 32'h0, got);
        check("read_back", got, 32'hDEAD_BEEF);
        @(negedge clk);
        check1("idle_rvalid", d_rvalid, 1'b0);
        check("idle_rdata", d_rdata, 32'h0);
        check1("idle_busy", d_busy, 1'b0);

        // byte-lane write, then an all-disabled write that must change nothing
        d_xfer(1'b1, 32'h0001_0020, 4'hF, 32'h1122_3344, got);
        d_xfer(1'b1, 32'h0001_0020, 4'b0100, 32'h00AA_0000, got);
        d_xfer(1'b0, 32'h0001_0020, 4'hF, 32'h0, got);
        check("byte_lane", got, 32'h11AA_3344);
        d_xfer(1'b1, 32'h0001_0020, 4'h0, 32'hFFFF_FFFF, got);
        d_xfer(1'b0, 32'h0001_0020, 4'hF, 32'h0, got);
        check("be_none", got, 32'h11AA_3344);

        // out of range on both sides; word 0 must survive the write at widx 1024
        d_xfer(1'b1, 32'h0001_0000, 4'hF, 32'hCAFE_F00D, got);
        d_xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0, got);
        d_xfer(1'b1, 32'h0001_1000, 4'hF, 32'h1234_5678, got);
        d_xfer(1'b0, 32'h0001_0000, 4'hF, 32'h0, got);
        check("oor_unchanged", got, 32'hCAFE_F00D);
        d_xfer(1'b1, 32'h0001_0FFC, 4'hF, 32'h0BAD_CAFE, got);
        d_xfer(1'b0, 32'h0001_0FFF, 4'hF, 32'h0, got);

        // misaligned split: failing first half does not suppress the second
        d_xfer(1'b0, 32'h0000_FFFE, 4'hF, 32'h0, got);
        d_xfer(1'b0, 32'h0001_0002, 4'hF, 32'h0, got);

        // randomized traffic over 16 preloaded words plus stray addresses
        for (int i = 0; i < 16; i++) begin
            d_xfer(1'b1, Base + 32'h100 + 32'(i * 4), 4'hF, $urandom, got);
        end
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom_range(1));
            be = 4'($urandom_range(15));
            wd = $urandom;
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(2))
                    0:       a = Base - 32'(4 - $urandom_range(3));
                    1:       a = Base + 32'h1000 + 32'($urandom_range(255) * 4);
                    default: a = 32'h8000_0000 | $urandom;
                endcase
            end else begin
                a = Base + 32'h100 + 32'($urandom_range(15) * 4) + 32'($urandom_range(3));
            end
            d_xfer(we, a, be, wd, got);
        end

        // back-to-back: write then read of the same word in consecutive cycles
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            a  = Base + 32'h200 + 32'((k / 2) * 4);
            we = ((k % 2) == 0);
            wd = $urandom;
            model(we, a, 4'hF, wd, e, rd);
            exp_q.push_back({e, rd});
            @(posedge clk); #1;
            d_drive(we, a, 4'hF, wd);
            @(negedge clk);
            check1("b2b_gnt", d_gnt, 1'b1);
            if (k > 0) begin
                exp_e = exp_q.pop_front();
                check1("b2b_rvalid", d_rvalid, 1'b1);
                check1("b2b_err", d_err, exp_e[32]);
                check("b2b_rdata", d_rdata, exp_e[31:0]);
                check("b2b_out", 32'(d_out), 32'h1);
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        exp_e = exp_q.pop_front();
        check1("b2b_last_rvalid", d_rvalid, 1'b1);
        check("b2b_last_rdata", d_rdata, exp_e[31:0]);
        @(negedge clk);
        check1("b2b_drained", d_busy, 1'b0);

        // stalled instance: preload, then hold req across 4 reads
        for (int i = 0; i < 4; i++) begin
            s_data[i] = $urandom;
            s_write(Base + 32'h40 + 32'(i * 4), s_data[i]);
        end
        @(posedge clk); #1;
        s_req = 1'b1; s_we = 1'b0; s_be = 4'h0; s_addr = Base + 32'h40;
        n_gnt = 0; n_rsp = 0; cyc = 0;
        while (n_rsp < 4 && cyc < 60) begin
            @(negedge clk);
            check1("s_out_bound", s_out <= 2'd2, 1'b1);
            saw_gnt = s_gnt;
            if (s_gnt) begin
                if (n_gnt == 0) check("s_first_gnt_cycle", 32'(cyc), 32'd2);
                n_gnt++;
            end
            if (s_rvalid) begin
                check1("s_rd_err", s_err, 1'b0);
                check("s_rd_data", s_rdata, s_data[n_rsp]);
                n_rsp++;
            end
            @(posedge clk); #1;
            if (saw_gnt) begin
                if (n_gnt < 4) s_addr = Base + 32'h40 + 32'(n_gnt * 4);
                else s_req = 1'b0;
            end
            cyc++;
        end
        check("s_rsp_count", 32'(n_rsp), 32'd4);
        s_req = 1'b0;

        // reset between grant and response drops the pending answer
        @(posedge clk); #1;
        d_drive(1'b0, 32'h0001_0000, 4'hF, '0);
        @(negedge clk);
        check1("mr_gnt0", d_gnt, 1'b1);
        @(posedge clk); #1;
        d_addr = 32'h0001_0004;
        @(negedge clk);
        check1("mr_gnt1", d_gnt, 1'b1);
        check1("mr_rvalid0", d_rvalid, 1'b1);
        check("mr_rdata0", d_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        rst_n = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check1("mr_rst_rvalid", d_rvalid, 1'b0);
        check("mr_rst_out", 32'(d_out), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("mr_no_stale", d_rvalid, 1'b0);
        end
        check("mr_out_after", 32'(d_out), 32'h0);
        d_xfer(1'b0, 32'h0001_0000, 4'hF, 32'h0, got);
        check("mr_served", got, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
